// File: rtl/lpddr5x_banked_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : lpddr5x_banked_ctrl
// Brief    : Banked LPDDR5x behavioural controller with in-order command FIFO,
//            per-bank open-row tracking, tRP/tRCD/CL timing, periodic refresh.
//            Optional: LPDDR5X_PERF_CNT_EN adds saturating performance counters.
// Revision : 1.0 - initial release
// ============================================================================
module lpddr5x_banked_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 512,
  parameter int MEM_DEPTH_LOG2 = 12,
  parameter int NUM_BANKS      = 4,
  parameter int COL_BITS       = 4,
  parameter int CMD_FIFO_DEPTH = 4,
  parameter int TAG_WIDTH      = 4,
  parameter int T_RP           = 3,
  parameter int T_RCD          = 3,
  parameter int T_CL           = 4,
  parameter int T_REFI         = 1024,
  parameter int T_RFC          = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [DATA_WIDTH-1:0] cmd_wdata_i,
  input  logic                  cmd_write_i,
  input  logic [TAG_WIDTH-1:0]  cmd_tag_i,
  output logic                  rsp_valid_o,
  output logic [DATA_WIDTH-1:0] rsp_rdata_o,
  output logic [TAG_WIDTH-1:0]  rsp_tag_o,
  output logic                  refresh_busy_o
`ifdef LPDDR5X_PERF_CNT_EN
  ,
  output logic [31:0]           perf_row_hit_o,
  output logic [31:0]           perf_row_miss_o,
  output logic [31:0]           perf_refresh_o
`endif
);

  localparam int c_bank_bits = $clog2(NUM_BANKS);
  localparam int c_row_bits  = MEM_DEPTH_LOG2 - c_bank_bits - COL_BITS;
  localparam int c_ptr_bits  = $clog2(CMD_FIFO_DEPTH);
  localparam int c_tmax_a    = (T_RP > T_RCD) ? T_RP : T_RCD;
  localparam int c_tmax_b    = (T_CL > T_RFC) ? T_CL : T_RFC;
  localparam int c_tmax      = (c_tmax_a > c_tmax_b) ? c_tmax_a : c_tmax_b;
  localparam int c_tcnt_bits = (c_tmax > 1) ? $clog2(c_tmax) : 1;
  localparam int c_refi_bits = $clog2(T_REFI);

  localparam logic [c_tcnt_bits-1:0] c_trp   = c_tcnt_bits'(T_RP - 1);
  localparam logic [c_tcnt_bits-1:0] c_trcd  = c_tcnt_bits'(T_RCD - 1);
  localparam logic [c_tcnt_bits-1:0] c_tcl   = c_tcnt_bits'(T_CL - 1);
  localparam logic [c_tcnt_bits-1:0] c_trfc  = c_tcnt_bits'(T_RFC - 1);
  localparam logic [c_tcnt_bits-1:0] c_tzero = '0;
  localparam logic [c_refi_bits-1:0] c_refi_last = c_refi_bits'(T_REFI - 1);
  localparam logic [c_ptr_bits:0]    c_fifo_full = (c_ptr_bits + 1)'(CMD_FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PRECHARGE = 3'd1,
    ST_ACTIVATE  = 3'd2,
    ST_ACCESS    = 3'd3,
    ST_REFRESH   = 3'd4
  } state_t;

  state_t                      r_state, w_state_nxt;
  logic [c_tcnt_bits-1:0]      r_tcnt, w_tcnt_nxt;
  logic                        w_pop, w_ref_start, w_push, w_hit;

  logic [MEM_DEPTH_LOG2-1:0]   r_fifo_w     [CMD_FIFO_DEPTH];
  logic [DATA_WIDTH-1:0]       r_fifo_data  [CMD_FIFO_DEPTH];
  logic                        r_fifo_write [CMD_FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]        r_fifo_tag   [CMD_FIFO_DEPTH];
  logic [c_ptr_bits-1:0]       r_wr_ptr, r_rd_ptr;
  logic [c_ptr_bits:0]         r_count;

  logic [MEM_DEPTH_LOG2-1:0]   r_cur_w;
  logic [DATA_WIDTH-1:0]       r_cur_wdata;
  logic                        r_cur_write;
  logic [TAG_WIDTH-1:0]        r_cur_tag;

  logic [NUM_BANKS-1:0]        r_bank_open;
  logic [c_row_bits-1:0]       r_bank_row [NUM_BANKS];
  logic [c_refi_bits-1:0]      r_refcnt;
  logic                        r_ref_pend;
  logic [DATA_WIDTH-1:0]       r_mem [2**MEM_DEPTH_LOG2];

  logic [MEM_DEPTH_LOG2-1:0]   w_head_w;
  logic [c_bank_bits-1:0]      w_head_bank, w_cur_bank;
  logic [c_row_bits-1:0]       w_head_row, w_cur_row;
  logic                        w_unused;

  assign w_unused    = ^{cmd_addr_i[ADDR_WIDTH-1:MEM_DEPTH_LOG2+2], cmd_addr_i[1:0]};
  assign cmd_ready_o = (r_count != c_fifo_full);
  assign w_push      = cmd_valid_i && cmd_ready_o;
  assign w_head_w    = r_fifo_w[r_rd_ptr];
  assign w_head_bank = w_head_w[c_bank_bits-1:0];
  assign w_head_row  = w_head_w[MEM_DEPTH_LOG2-1 -: c_row_bits];
  assign w_cur_bank  = r_cur_w[c_bank_bits-1:0];
  assign w_cur_row   = r_cur_w[MEM_DEPTH_LOG2-1 -: c_row_bits];
  assign w_hit       = r_bank_open[w_head_bank] && (r_bank_row[w_head_bank] == w_head_row);
  assign refresh_busy_o = (r_state == ST_REFRESH);

  always_comb begin
    w_state_nxt = r_state;
    w_tcnt_nxt  = r_tcnt;
    w_pop       = 1'b0;
    w_ref_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (r_ref_pend) begin
          w_state_nxt = ST_REFRESH;
          w_tcnt_nxt  = c_trfc;
          w_ref_start = 1'b1;
        end else if (r_count != '0) begin
          w_pop = 1'b1;
          if (w_hit) begin
            w_state_nxt = ST_ACCESS;
            w_tcnt_nxt  = r_fifo_write[r_rd_ptr] ? c_tzero : c_tcl;
          end else if (!r_bank_open[w_head_bank]) begin
            w_state_nxt = ST_ACTIVATE;
            w_tcnt_nxt  = c_trcd;
          end else begin
            w_state_nxt = ST_PRECHARGE;
            w_tcnt_nxt  = c_trp;
          end
        end
      end
      ST_PRECHARGE: begin
        if (r_tcnt == c_tzero) begin
          w_state_nxt = ST_ACTIVATE;
          w_tcnt_nxt  = c_trcd;
        end else begin
          w_tcnt_nxt  = r_tcnt - c_tcnt_bits'(1);
        end
      end
      ST_ACTIVATE: begin
        if (r_tcnt == c_tzero) begin
          w_state_nxt = ST_ACCESS;
          w_tcnt_nxt  = r_cur_write ? c_tzero : c_tcl;
        end else begin
          w_tcnt_nxt  = r_tcnt - c_tcnt_bits'(1);
        end
      end
      ST_ACCESS, ST_REFRESH: begin
        if (r_tcnt == c_tzero) w_state_nxt = ST_IDLE;
        else                   w_tcnt_nxt  = r_tcnt - c_tcnt_bits'(1);
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= ST_IDLE;
      r_tcnt      <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_bank_open <= '0;
      r_refcnt    <= '0;
      r_ref_pend  <= 1'b0;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_tag_o   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_tcnt  <= w_tcnt_nxt;
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_bits'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_bits'(1);
      r_count <= r_count + {{c_ptr_bits{1'b0}}, w_push} - {{c_ptr_bits{1'b0}}, w_pop};
      // A new expiry on the same cycle refresh starts must not be lost.
      if (r_refcnt == c_refi_last) begin
        r_refcnt   <= '0;
        r_ref_pend <= 1'b1;
      end else begin
        r_refcnt <= r_refcnt + c_refi_bits'(1);
        if (w_ref_start) r_ref_pend <= 1'b0;
      end
      if (w_ref_start) r_bank_open <= '0;
      if (r_state == ST_PRECHARGE && r_tcnt == c_tzero) r_bank_open[w_cur_bank] <= 1'b0;
      if (r_state == ST_ACTIVATE && r_tcnt == c_tzero)  r_bank_open[w_cur_bank] <= 1'b1;
      rsp_valid_o <= (r_state == ST_ACCESS) && (r_tcnt == c_tzero) && !r_cur_write;
      if ((r_state == ST_ACCESS) && (r_tcnt == c_tzero) && !r_cur_write) begin
        rsp_rdata_o <= r_mem[r_cur_w];
        rsp_tag_o   <= r_cur_tag;
      end
    end
  end

  // Datapath storage without reset; the array survives rst_i.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_w[r_wr_ptr]     <= cmd_addr_i[MEM_DEPTH_LOG2+1:2];
      r_fifo_data[r_wr_ptr]  <= cmd_wdata_i;
      r_fifo_write[r_wr_ptr] <= cmd_write_i;
      r_fifo_tag[r_wr_ptr]   <= cmd_tag_i;
    end
    if (w_pop) begin
      r_cur_w     <= w_head_w;
      r_cur_wdata <= r_fifo_data[r_rd_ptr];
      r_cur_write <= r_fifo_write[r_rd_ptr];
      r_cur_tag   <= r_fifo_tag[r_rd_ptr];
    end
    if (!rst_i && r_state == ST_ACTIVATE && r_tcnt == c_tzero) r_bank_row[w_cur_bank] <= w_cur_row;
    if (!rst_i && r_state == ST_ACCESS && r_cur_write) r_mem[r_cur_w] <= r_cur_wdata;
  end

`ifdef LPDDR5X_PERF_CNT_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      perf_row_hit_o  <= '0;
      perf_row_miss_o <= '0;
      perf_refresh_o  <= '0;
    end else begin
      if (w_pop && w_hit && perf_row_hit_o != '1)    perf_row_hit_o  <= perf_row_hit_o + 32'd1;
      if (w_pop && !w_hit && perf_row_miss_o != '1)  perf_row_miss_o <= perf_row_miss_o + 32'd1;
      if (w_ref_start && perf_refresh_o != '1)       perf_refresh_o  <= perf_refresh_o + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_lpddr5x_banked_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_lpddr5x_banked_ctrl
// Brief    : Directed self-checking bench for lpddr5x_banked_ctrl (T_REFI=64).
// Revision : 1.0 - initial release
// ============================================================================
module tb_lpddr5x_banked_ctrl;
  localparam int AW = 32;
  localparam int DW = 512;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_wdata;
  logic          cmd_write;
  logic [TW-1:0] cmd_tag;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic [TW-1:0] rsp_tag;
  logic          refresh_busy;
`ifdef LPDDR5X_PERF_CNT_EN
  logic [31:0]   perf_row_hit, perf_row_miss, perf_refresh;
`endif

  int n_pass  = 0;
  int n_total = 0;
  logic [DW-1:0] c_pat_a5 = {64{8'hA5}};

  always #5 clk = ~clk;

  lpddr5x_banked_ctrl #(.T_REFI(64), .T_RFC(8)) u_dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .cmd_valid_i    (cmd_valid),
    .cmd_ready_o    (cmd_ready),
    .cmd_addr_i     (cmd_addr),
    .cmd_wdata_i    (cmd_wdata),
    .cmd_write_i    (cmd_write),
    .cmd_tag_i      (cmd_tag),
    .rsp_valid_o    (rsp_valid),
    .rsp_rdata_o    (rsp_rdata),
    .rsp_tag_o      (rsp_tag),
    .refresh_busy_o (refresh_busy)
`ifdef LPDDR5X_PERF_CNT_EN
    ,
    .perf_row_hit_o (perf_row_hit),
    .perf_row_miss_o(perf_row_miss),
    .perf_refresh_o (perf_refresh)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst       = 1'b1;
    cmd_valid = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Returns in the cycle after acceptance.
  task automatic send(input logic [AW-1:0] addr, input logic wr,
                      input logic [DW-1:0] data, input logic [TW-1:0] tag);
    int guard = 0;
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_write = wr;
    cmd_wdata = data;
    cmd_tag   = tag;
    while (!cmd_ready && guard < 200) begin
      step();
      guard++;
    end
    if (guard >= 200) begin
      n_total++;
      $display("FAIL send_timeout: cmd_ready stayed %0b, want 1", cmd_ready);
    end
    step();
    cmd_valid = 1'b0;
  endtask

  // Latency counted from the acceptance cycle; also reports rsp_valid one cycle later.
  task automatic wait_rsp(output int lat, output logic [DW-1:0] d,
                          output logic [TW-1:0] t, output logic after);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      step();
      lat++;
    end
    d = rsp_rdata;
    t = rsp_tag;
    step();
    after = rsp_valid;
  endtask

  task automatic test_reset();
    int lat; logic [DW-1:0] d; logic [TW-1:0] t; logic a;
    apply_reset();
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %0b want 1", cmd_ready); else n_pass++;
    n_total++; if (rsp_valid !== 1'b0) $display("FAIL rst_valid: got %0b want 0", rsp_valid); else n_pass++;
    n_total++; if (refresh_busy !== 1'b0) $display("FAIL rst_busy: got %0b want 0", refresh_busy); else n_pass++;
    n_total++; if (rsp_rdata !== '0) $display("FAIL rst_rdata: got %0h want 0", rsp_rdata); else n_pass++;
    n_total++; if (rsp_tag !== '0) $display("FAIL rst_tag: got %0h want 0", rsp_tag); else n_pass++;
    send(32'h0, 1'b0, '0, 4'd1);
    wait_rsp(lat, d, t, a);
    n_total++; if (lat !== 9) $display("FAIL closed_lat: got %0d want 9", lat); else n_pass++;
    n_total++; if (t !== 4'd1) $display("FAIL closed_tag: got %0d want 1", t); else n_pass++;
  endtask

  task automatic test_row_hit();
    int lat; logic [DW-1:0] d; logic [TW-1:0] t; logic a;
    apply_reset();
    send(32'h0, 1'b1, c_pat_a5, 4'd0);
    repeat (8) step();
    send(32'h0, 1'b0, '0, 4'd3);
    wait_rsp(lat, d, t, a);
    n_total++; if (lat !== 6) $display("FAIL hit_lat: got %0d want 6", lat); else n_pass++;
    n_total++; if (d !== c_pat_a5) $display("FAIL hit_data: got %0h want %0h", d, c_pat_a5); else n_pass++;
    n_total++; if (t !== 4'd3) $display("FAIL hit_tag: got %0d want 3", t); else n_pass++;
    n_total++; if (a !== 1'b0) $display("FAIL hit_pulse: valid after pulse %0b want 0", a); else n_pass++;
  endtask

  task automatic test_row_conflict();
    int lat; logic [DW-1:0] d; logic [TW-1:0] t; logic a;
    apply_reset();
    send(32'h0, 1'b0, '0, 4'd0);
    wait_rsp(lat, d, t, a);
    send(32'h100, 1'b0, '0, 4'd5);
    wait_rsp(lat, d, t, a);
    n_total++; if (lat !== 12) $display("FAIL conflict_lat: got %0d want 12", lat); else n_pass++;
    n_total++; if (t !== 4'd5) $display("FAIL conflict_tag: got %0d want 5", t); else n_pass++;
    send(32'h100, 1'b0, '0, 4'd6);
    wait_rsp(lat, d, t, a);
    n_total++; if (lat !== 6) $display("FAIL rehit_lat: got %0d want 6", lat); else n_pass++;
    n_total++; if (t !== 4'd6) $display("FAIL rehit_tag: got %0d want 6", t); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [TW-1:0] tags [8];
    int rcv = 0;
    int acc_at_drop = -1;
    apply_reset();
    fork
      begin : g_send
        int i = 0;
        int acc = 0;
        int guard = 0;
        logic take;
        while (i < 8 && guard < 400) begin
          cmd_valid = 1'b1;
          cmd_addr  = 32'((i % 4) * 4);
          cmd_write = 1'b0;
          cmd_wdata = '0;
          cmd_tag   = TW'(i);
          take = cmd_ready;
          if (!take && acc_at_drop < 0) acc_at_drop = acc;
          step();
          guard++;
          if (take) begin
            i++;
            acc++;
          end
        end
        cmd_valid = 1'b0;
      end
      begin : g_collect
        int cyc = 0;
        while (rcv < 8 && cyc < 400) begin
          if (rsp_valid) begin
            tags[rcv] = rsp_tag;
            rcv++;
          end
          step();
          cyc++;
        end
      end
    join
    n_total++; if (acc_at_drop !== 5) $display("FAIL full_drop: accepted %0d before ready low, want 5", acc_at_drop); else n_pass++;
    n_total++; if (rcv !== 8) $display("FAIL b2b_count: got %0d responses want 8", rcv); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      n_total++;
      if (k >= rcv || tags[k] !== TW'(k)) $display("FAIL b2b_order[%0d]: got %0d want %0d", k, tags[k], k);
      else n_pass++;
    end
  endtask

  task automatic test_refresh();
    int lat; logic [DW-1:0] d; logic [TW-1:0] t; logic a;
    int busy_n = 0;
    apply_reset();
    repeat (58) step();
    send(32'h0, 1'b0, '0, 4'd2);
    wait_rsp(lat, d, t, a);
    n_total++; if (lat !== 9) $display("FAIL ref_inflight_lat: got %0d want 9", lat); else n_pass++;
    n_total++; if (refresh_busy !== 1'b1) $display("FAIL ref_start: busy %0b want 1 after response", refresh_busy); else n_pass++;
    while (refresh_busy && busy_n < 40) begin
      busy_n++;
      step();
    end
    n_total++; if (busy_n !== 8) $display("FAIL ref_len: busy %0d cycles want 8", busy_n); else n_pass++;
    send(32'h0, 1'b0, '0, 4'd4);
    wait_rsp(lat, d, t, a);
    n_total++; if (lat !== 9) $display("FAIL ref_after_lat: got %0d want 9", lat); else n_pass++;
    n_total++; if (t !== 4'd4) $display("FAIL ref_after_tag: got %0d want 4", t); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int lat; logic [DW-1:0] d; logic [TW-1:0] t; logic a;
    int pulses = 0;
    apply_reset();
    send(32'h0, 1'b0, '0, 4'd7);
    send(32'h0, 1'b0, '0, 4'd8);
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    n_total++; if (cmd_ready !== 1'b1) $display("FAIL mid_rst_ready: got %0b want 1", cmd_ready); else n_pass++;
    repeat (15) begin
      if (rsp_valid) pulses++;
      step();
    end
    n_total++; if (pulses !== 0) $display("FAIL mid_rst_discard: got %0d pulses want 0", pulses); else n_pass++;
    send(32'h0, 1'b0, '0, 4'd9);
    wait_rsp(lat, d, t, a);
    n_total++; if (d !== c_pat_a5) $display("FAIL mid_rst_data: got %0h want %0h", d, c_pat_a5); else n_pass++;
    n_total++; if (t !== 4'd9) $display("FAIL mid_rst_tag: got %0d want 9", t); else n_pass++;
    n_total++; if (lat !== 9) $display("FAIL mid_rst_lat: got %0d want 9", lat); else n_pass++;
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    cmd_write = 1'b0;
    cmd_tag   = '0;
    test_reset();
    test_row_hit();
    test_row_conflict();
    test_back_to_back();
    test_refresh();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
